// File: rtl/lcd_pkg.sv
// Shared state encodings, HD44780-style command bytes and small helpers for the LCD refresh controller.
// Pure declarations: no latency, no flow control.
package lcd_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT_CMD,
    IDLE,
    ADDR,
    FETCH,
    WRITE,
    WAIT
  } state_t;

  typedef enum logic [2:0] {
    W_IDLE,
    W_SETUP,
    W_PULSE,
    W_HOLD,
    W_WAIT
  } wr_state_t;

  typedef enum logic [1:0] {
    K_INIT,
    K_ADDR,
    K_CHAR
  } kind_t;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_LINE1    = 8'h80;
  localparam logic [7:0] CMD_LINE2    = 8'hC0;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] step);
    logic [7:0] c;
    case (step)
      2'd0:    c = CMD_FUNC_SET;
      2'd1:    c = CMD_DISP_ON;
      2'd2:    c = CMD_ENTRY;
      default: c = CMD_CLEAR;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// Writes one byte to the LCD: 1 setup cycle, E_PULSE cycles of e high, 1 hold cycle, then wait_len idle cycles.
// done is high during the last cycle of the byte; go is only accepted while idle.
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int unsigned E_PULSE = 4,
  parameter int unsigned WW      = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          go,
  input  logic          rs,
  input  logic [7:0]    data,
  input  logic [WW-1:0] wait_len,
  output logic          done,
  output logic          lcd_rs,
  output logic          lcd_e,
  output logic [7:0]    lcd_data
);

  localparam int unsigned PW = (E_PULSE > 1) ? $clog2(E_PULSE) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(E_PULSE - 1);

  wr_state_t     wst;
  logic [PW-1:0] pcnt;
  logic [WW-1:0] wlen;
  logic [WW-1:0] rem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wst      <= W_IDLE;
      pcnt     <= '0;
      wlen     <= '0;
      rem      <= '0;
      done     <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_e    <= 1'b0;
      lcd_data <= 8'h00;
    end else begin
      done <= 1'b0;
      case (wst)
        W_IDLE: begin
          if (go) begin
            lcd_rs   <= rs;
            lcd_data <= data;
            wlen     <= wait_len;
            wst      <= W_SETUP;
          end
        end
        W_SETUP: begin
          lcd_e <= 1'b1;
          pcnt  <= '0;
          wst   <= W_PULSE;
        end
        W_PULSE: begin
          if (pcnt == P_LAST) begin
            lcd_e <= 1'b0;
            done  <= (wlen == '0);
            wst   <= W_HOLD;
          end else begin
            pcnt <= pcnt + 1'b1;
          end
        end
        W_HOLD: begin
          if (wlen == '0) begin
            wst <= W_IDLE;
          end else begin
            // rem counts the wait cycles still to go after the current one
            rem  <= wlen - 1'b1;
            done <= (wlen == WW'(1));
            wst  <= W_WAIT;
          end
        end
        W_WAIT: begin
          if (rem == '0) begin
            wst <= W_IDLE;
          end else begin
            rem  <= rem - 1'b1;
            done <= (rem == WW'(1));
          end
        end
        default: wst <= W_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/lcd_refresh_ctrl.sv
// Power-up init of a 2x16 character LCD, then on request refreshes both lines from a registered character source.
// Each character is fetched with a 2-cycle source latency; start is a level, sampled only in IDLE.
module lcd_refresh_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned E_PULSE   = 4,
  parameter int unsigned INIT_WAIT = 20000,
  parameter int unsigned CMD_WAIT  = 2000,
  parameter int unsigned CLR_WAIT  = 80000,
  parameter int unsigned CHAR_WAIT = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] char_in,
  output logic [4:0] index,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned WAIT_MAX = max_u(max_u(INIT_WAIT, CLR_WAIT), max_u(CMD_WAIT, CHAR_WAIT));
  localparam int unsigned WW       = $clog2(WAIT_MAX + 1);

  localparam logic [WW-1:0] INIT_LAST = WW'(INIT_WAIT - 1);
  localparam logic [WW-1:0] CMD_LEN   = WW'(CMD_WAIT);
  localparam logic [WW-1:0] CLR_LEN   = WW'(CLR_WAIT);
  localparam logic [WW-1:0] CHAR_LEN  = WW'(CHAR_WAIT);

  state_t        state;
  kind_t         kind;
  logic [WW-1:0] cnt;
  logic [1:0]    init_idx;
  logic [1:0]    fph;
  logic [4:0]    pos;
  logic          go;
  logic          wr_rs;
  logic [7:0]    wr_dat;
  logic [WW-1:0] wr_len;
  logic          wr_done;

  assign lcd_rw = 1'b0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= PWR_WAIT;
      kind       <= K_INIT;
      cnt        <= '0;
      init_idx   <= 2'd0;
      fph        <= 2'd0;
      pos        <= 5'd0;
      go         <= 1'b0;
      wr_rs      <= 1'b0;
      wr_dat     <= 8'h00;
      wr_len     <= '0;
      index      <= 5'd0;
      busy       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      go         <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        PWR_WAIT: begin
          if (cnt == INIT_LAST) begin
            cnt   <= '0;
            state <= INIT_CMD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        INIT_CMD: begin
          go     <= 1'b1;
          wr_rs  <= 1'b0;
          wr_dat <= init_cmd(init_idx);
          wr_len <= (init_idx == 2'd3) ? CLR_LEN : CMD_LEN;
          kind   <= K_INIT;
          state  <= WAIT;
        end
        IDLE: begin
          if (start) begin
            pos   <= 5'd0;
            busy  <= 1'b1;
            state <= ADDR;
          end
        end
        ADDR: begin
          go     <= 1'b1;
          wr_rs  <= 1'b0;
          wr_dat <= pos[4] ? CMD_LINE2 : CMD_LINE1;
          wr_len <= CMD_LEN;
          kind   <= K_ADDR;
          state  <= WAIT;
        end
        FETCH: begin
          // The source answers one cycle after it sees index, so sample on the second edge.
          case (fph)
            2'd0: begin
              index <= pos;
              fph   <= 2'd1;
            end
            2'd1: fph <= 2'd2;
            default: begin
              wr_dat <= char_in;
              fph    <= 2'd0;
              state  <= WRITE;
            end
          endcase
        end
        WRITE: begin
          go     <= 1'b1;
          wr_rs  <= 1'b1;
          wr_len <= CHAR_LEN;
          kind   <= K_CHAR;
          state  <= WAIT;
        end
        WAIT: begin
          if (wr_done) begin
            case (kind)
              K_INIT: begin
                if (init_idx == 2'd3) begin
                  busy  <= 1'b0;
                  state <= IDLE;
                end else begin
                  init_idx <= init_idx + 2'd1;
                  state    <= INIT_CMD;
                end
              end
              K_ADDR: state <= FETCH;
              K_CHAR: begin
                if (pos == 5'd31) begin
                  frame_done <= 1'b1;
                  busy       <= 1'b0;
                  state      <= IDLE;
                end else if (pos == 5'd15) begin
                  pos   <= 5'd16;
                  state <= ADDR;
                end else begin
                  pos   <= pos + 5'd1;
                  state <= FETCH;
                end
              end
              default: begin
                busy  <= 1'b0;
                state <= IDLE;
              end
            endcase
          end
        end
        default: begin
          busy  <= 1'b1;
          state <= PWR_WAIT;
        end
      endcase
    end
  end

  lcd_byte_writer #(
    .E_PULSE(E_PULSE),
    .WW     (WW)
  ) u_writer (
    .clk     (clk),
    .rst     (rst),
    .go      (go),
    .rs      (wr_rs),
    .data    (wr_dat),
    .wait_len(wr_len),
    .done    (wr_done),
    .lcd_rs  (lcd_rs),
    .lcd_e   (lcd_e),
    .lcd_data(lcd_data)
  );

endmodule

// File: doc/lcd_refresh_ctrl.md
LCD_REFRESH_CTRL -- requirements
Module: lcd_refresh_ctrl

Interface
REQ-001 SHALL have parameter E_PULSE, default 4, meaning the number of clk cycles lcd_e is held high per byte.
REQ-002 SHALL have parameter INIT_WAIT, default 20000, meaning the clk cycles of power-up wait before the first command.
REQ-003 SHALL have parameter CMD_WAIT, default 2000, meaning the clk cycles of wait after each command byte, excluding clear.
REQ-004 SHALL have parameter CLR_WAIT, default 80000, meaning the clk cycles of wait after the clear command 0x01.
REQ-005 SHALL have parameter CHAR_WAIT, default 50, meaning the clk cycles of wait after each data byte.
REQ-006 SHALL have port clk, input, 1 bit: the single system clock, rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port start, input, 1 bit: level request to refresh the display.
REQ-009 SHALL have port char_in, input, 8 bits: ASCII character returned by the display-mode source for the current index.
REQ-010 SHALL have port index, output, 5 bits: character position requested from the source (0-15 line 1, 16-31 line 2).
REQ-011 SHALL have ports lcd_rs, lcd_rw and lcd_e, outputs, 1 bit each: LCD register select, read/write and enable.
REQ-012 SHALL have port lcd_data, output, 8 bits: LCD data bus.
REQ-013 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-014 SHALL have port frame_done, output, 1 bit: one-cycle pulse after byte 31 completes.

Function
REQ-015 SHALL use the states PWR_WAIT, INIT_CMD, IDLE, ADDR, FETCH, WRITE and WAIT.
REQ-016 SHALL, after reset, enter PWR_WAIT for INIT_WAIT cycles, then issue 0x38, 0x0C, 0x06, 0x01 in order with lcd_rs=0, then enter IDLE.
REQ-017 SHALL, in IDLE with start=1, issue command 0x80 (line-1 address), then data bytes for index 0..15, then command 0xC0, then data bytes for index 16..31.
REQ-018 SHALL perform each byte write as: 1 setup cycle (rs and data stable, e=0), then E_PULSE cycles with e=1, then 1 hold cycle with e=0, then the applicable wait.
REQ-019 SHALL keep lcd_data and lcd_rs constant from the setup cycle through the hold cycle.
REQ-020 SHALL drive lcd_rw=0 at all times.
REQ-021 SHALL change index only in FETCH and capture char_in exactly 2 cycles after the index update, because the source registers its output one cycle late.
REQ-022 SHALL assert frame_done for exactly one cycle after the CHAR_WAIT of byte 31, then return to IDLE.
REQ-023 SHALL start the next frame with no extra idle cycle if start is still 1 at that point.
REQ-024 SHALL complete the current frame when start falls mid-frame and then stay in IDLE.
REQ-025 SHALL ignore start during PWR_WAIT and INIT_CMD, acting on it only from IDLE.
REQ-026 SHALL size its wait counter to hold max(INIT_WAIT, CLR_WAIT) and SHALL compare against exactly the parameter value, with no off-by-one.
REQ-027 SHALL wrap index from 31 to 0 only on frame start, never by natural overflow mid-frame.

Reset
REQ-028 SHALL, on rst low at any time, asynchronously force lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=8'h00, index=0, busy=1, frame_done=0, all counters to 0 and the state to PWR_WAIT.
REQ-029 SHALL rerun the full init sequence after reset, including a reset taken mid-frame or mid-pulse.

Structure
REQ-030 SHALL place the state enum and the LCD command constants (0x38, 0x0C, 0x06, 0x01, 0x80, 0xC0) in the shared package lcd_pkg.
REQ-031 SHALL implement the single-byte setup/E-pulse/hold/wait sequencing in the sub-module lcd_byte_writer (inputs go, rs, data, wait_len; output done).
REQ-032 SHALL keep frame sequencing and index generation in lcd_refresh_ctrl.

Verification (E_PULSE=2, INIT_WAIT=10, CMD_WAIT=5, CLR_WAIT=8, CHAR_WAIT=3)
REQ-033 SHALL verify: release reset -> no lcd_e for 10 cycles, then E pulses carrying 0x38, 0x0C, 0x06, 0x01 with rs=0, each e high for exactly 2 cycles, 8-cycle gap after 0x01 -> IDLE, busy=0.
REQ-034 SHALL verify: start=1 for 1 cycle, source model returns 8'h40+index -> bytes 0x80, 0x40..0x4F, 0xC0, 0x50..0x5F in order, rs=1 only on data bytes, one frame_done pulse.
REQ-035 SHALL verify: start held at 1 -> back-to-back frames with 0x80 issued on the cycle after frame_done, and index restarting at 0.
REQ-036 SHALL verify: start dropped at index 7 -> frame still finishes through index 31, then busy=0 and no further E pulses.
REQ-037 SHALL verify: rst pulsed low while lcd_e=1 at index 20 -> lcd_e=0 and index=0 in the same cycle, then the full init sequence repeats.
REQ-038 SHALL verify: char_in changed 1 cycle after index versus 2 cycles after -> only the value present 2 cycles after the index update is written.
